bitstream_byte_feeder: RTL and testbench

//  Byte source for the arithmetic decoder, sitting directly downstream of bitsNeeded:
//  it consumes request_byte and bitsNeededRB_out and returns the aligned byte for the
//  m_value update (m_value += byte << bitsNeededRB).

---
 rtl/bitstream_byte_feeder_pkg.sv | 21 ++
 rtl/bitstream_byte_feeder_if.sv | 24 ++
 rtl/bitstream_byte_feeder_byte_fifo.sv | 59 +++++
 rtl/mux2to1.sv | 13 +
 rtl/bitstream_byte_feeder.sv | 158 +++++++++++++++
 tb/tb_bitstream_byte_feeder.sv | 199 +++++++++++++++++++
 6 files changed

// File: rtl/bitstream_byte_feeder_pkg.sv
// Shared types and constants for the arithmetic-decoder byte feeder.
// Holds the FSM encoding and the byte-alignment helper used by the top level.
package bitstream_byte_feeder_pkg;

    localparam int BYTE_W     = 8;
    localparam int INIT_BYTES = 3;
    localparam int RB_W       = 4;
    localparam int SHIFT_W    = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic [SHIFT_W-1:0] align_byte(input logic [BYTE_W-1:0] b,
                                                      input logic [2:0]        sh);
        return {7'd0, b} << sh;
    endfunction

endpackage

// File: rtl/bitstream_byte_feeder_if.sv
// Byte-stream handshake between the memory interface / decoder and the feeder.
interface bitstream_byte_feeder_if;
    import bitstream_byte_feeder_pkg::*;

    logic [BYTE_W-1:0]  in_byte;
    logic               in_valid;
    logic               in_ready;
    logic               request_byte;
    logic [RB_W-1:0]    bitsNeededRB;
    logic               byte_valid;
    logic [SHIFT_W-1:0] byte_shifted;
    logic               stall;

    modport master (
        output in_byte, in_valid, request_byte, bitsNeededRB,
        input  in_ready, byte_valid, byte_shifted, stall
    );

    modport slave (
        input  in_byte, in_valid, request_byte, bitsNeededRB,
        output in_ready, byte_valid, byte_shifted, stall
    );

endinterface

// File: rtl/bitstream_byte_feeder_byte_fifo.sv
// Show-ahead byte FIFO: head is always the oldest entry, pop only advances the read pointer.
module bitstream_byte_feeder_byte_fifo
    import bitstream_byte_feeder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] head,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    assign push_ok_s = push && ((count_r < CNT_W'(DEPTH)) || pop_ok_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {BYTE_W{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/mux2to1.sv
// Generic two-input selector; picks b when sel is high, a otherwise.
module mux2to1 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/bitstream_byte_feeder.sv
// Byte source for the arithmetic decoder: assembles the 24-bit initial m_value at slice
// start, then serves FIFO bytes pre-shifted by bitsNeededRB with zero latency.
module bitstream_byte_feeder
    import bitstream_byte_feeder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    bitstream_byte_feeder_if.slave bus,
    output logic [23:0]            init_value,
    output logic                   init_done,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   proto_err
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         init_cnt_r;
    logic [15:0]        init_sr_r;
    logic [23:0]        init_value_r;
    logic               init_done_r;
    logic               proto_err_r;
    logic               in_ready_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               run_s;
    logic [BYTE_W-1:0]  head_s;
    logic [CNT_W-1:0]   count_s;
    logic [SHIFT_W-1:0] aligned_s;

    assign run_s    = (state_r == ST_RUN);
    // A negative shift (bit 3 set) is a protocol error and never consumes a byte.
    assign pop_s    = run_s && bus.request_byte && (count_s != {CNT_W{1'b0}})
                      && !bus.bitsNeededRB[3];
    assign accept_s = bus.in_valid && in_ready_s;
    assign push_s   = accept_s && run_s;

    // Input-side readiness per state; start blocks acceptance on its own cycle.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b0;
            ST_INIT: in_ready_s = 1'b1;
            ST_RUN:  in_ready_s = (count_s < CNT_W'(DEPTH)) || pop_s;
            default: in_ready_s = 1'b0;
        endcase
        if (start) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = in_ready_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = ST_IDLE;
            ST_INIT: begin
                if (accept_s && (init_cnt_r == 2'(INIT_BYTES - 1))) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_IDLE;
        endcase
        if (start) begin
            state_nxt_s = ST_INIT;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Initial m_value assembly; the last value is held until the next slice overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_r   <= 2'd0;
            init_sr_r    <= 16'd0;
            init_value_r <= 24'd0;
            init_done_r  <= 1'b0;
        end else if (start) begin
            init_cnt_r  <= 2'd0;
            init_done_r <= 1'b0;
        end else begin
            init_done_r <= 1'b0;
            if ((state_r == ST_INIT) && accept_s) begin
                if (init_cnt_r == 2'(INIT_BYTES - 1)) begin
                    init_value_r <= {init_sr_r, bus.in_byte};
                    init_done_r  <= 1'b1;
                    init_cnt_r   <= 2'd0;
                end else begin
                    init_sr_r  <= {init_sr_r[7:0], bus.in_byte};
                    init_cnt_r <= init_cnt_r + 2'd1;
                end
            end
        end
    end

    // Sticky protocol error, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_r <= 1'b0;
        end else if (bus.request_byte && (!run_s || bus.bitsNeededRB[3])) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    bitstream_byte_feeder_byte_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (push_s),
        .pop   (pop_s),
        .din   (bus.in_byte),
        .head  (head_s),
        .count (count_s)
    );

    assign aligned_s = align_byte(head_s, bus.bitsNeededRB[2:0]);

    mux2to1 #(
        .W (SHIFT_W)
    ) u_zero_mux (
        .a   ({SHIFT_W{1'b0}}),
        .b   (aligned_s),
        .sel (pop_s),
        .y   (bus.byte_shifted)
    );

    assign bus.in_ready   = in_ready_s;
    assign bus.byte_valid = pop_s;
    assign bus.stall      = run_s && bus.request_byte && (count_s == {CNT_W{1'b0}});
    assign init_value     = init_value_r;
    assign init_done      = init_done_r;
    assign fifo_count     = count_s;
    assign proto_err      = proto_err_r;

endmodule

// File: tb/tb_bitstream_byte_feeder.sv
// Directed self-checking bench for bitstream_byte_feeder.
module tb_bitstream_byte_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] init_value;
    logic        init_done;
    logic [2:0]  fifo_count;
    logic        proto_err;
    int          checks = 0;
    int          errors = 0;

    bitstream_byte_feeder_if bus ();

    bitstream_byte_feeder #(.DEPTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .init_value (init_value),
        .init_done  (init_done),
        .fifo_count (fifo_count),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic req, input logic [3:0] rb);
        bus.in_valid     = v;
        bus.in_byte      = b;
        bus.request_byte = req;
        bus.bitsNeededRB = rb;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte = 8'h00;
        bus.request_byte = 1'b0;
        bus.bitsNeededRB = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_count", 32'(fifo_count), 32'd0);
        chk("reset_init_value", 32'(init_value), 32'd0);
        chk("reset_byte_valid", 32'(bus.byte_valid), 32'd0);
        tick();

        // slice start, first byte ignored on the start cycle
        start = 1'b1;
        drive(1'b1, 8'h99, 1'b0, 4'd0);
        chk("start_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        start = 1'b0;
        drive(1'b1, 8'h12, 1'b0, 4'd0);
        chk("init_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 8'h34, 1'b0, 4'd0);
        tick();
        drive(1'b1, 8'h56, 1'b0, 4'd0);
        chk("init_done_early", 32'(init_done), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 4'd0);
        chk("init_done_pulse", 32'(init_done), 32'd1);
        chk("init_value", 32'(init_value), 32'h123456);
        chk("init_count", 32'(fifo_count), 32'd0);
        tick();
        chk("init_done_clear", 32'(init_done), 32'd0);

        // single byte, shift by 3
        drive(1'b1, 8'hA5, 1'b0, 4'd0);
        tick();
        chk("push_a5_count", 32'(fifo_count), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 4'd3);
        chk("rb3_valid", 32'(bus.byte_valid), 32'd1);
        chk("rb3_shifted", 32'(bus.byte_shifted), 32'h0528);
        chk("rb3_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("rb3_count", 32'(fifo_count), 32'd0);

        // fill, then push with pop while full
        drive(1'b1, 8'h11, 1'b0, 4'd0); tick();
        drive(1'b1, 8'h22, 1'b0, 4'd0); tick();
        drive(1'b1, 8'h33, 1'b0, 4'd0); tick();
        drive(1'b1, 8'h44, 1'b0, 4'd0); tick();
        drive(1'b1, 8'h55, 1'b0, 4'd0);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 8'h55, 1'b1, 4'd0);
        chk("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
        chk("full_pop_head", 32'(bus.byte_shifted), 32'h0011);
        tick();
        chk("full_pop_count", 32'(fifo_count), 32'd4);
        drive(1'b0, 8'h00, 1'b1, 4'd0);
        chk("order_1", 32'(bus.byte_shifted), 32'h0022); tick();
        chk("order_2", 32'(bus.byte_shifted), 32'h0033); tick();
        chk("order_3", 32'(bus.byte_shifted), 32'h0044); tick();
        chk("order_4", 32'(bus.byte_shifted), 32'h0055); tick();
        chk("drain_count", 32'(fifo_count), 32'd0);

        // empty stall, then push with no bypass
        drive(1'b0, 8'h00, 1'b1, 4'd7);
        for (int i = 0; i < 3; i++) begin
            chk("empty_stall", 32'(bus.stall), 32'd1);
            chk("empty_valid", 32'(bus.byte_valid), 32'd0);
            chk("empty_shifted", 32'(bus.byte_shifted), 32'd0);
            tick();
        end
        drive(1'b1, 8'hFF, 1'b1, 4'd7);
        chk("push_cycle_stall", 32'(bus.stall), 32'd1);
        chk("push_cycle_valid", 32'(bus.byte_valid), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 4'd7);
        chk("rb7_stall", 32'(bus.stall), 32'd0);
        chk("rb7_valid", 32'(bus.byte_valid), 32'd1);
        chk("rb7_shifted", 32'(bus.byte_shifted), 32'h7F80);
        tick();
        chk("rb7_count", 32'(fifo_count), 32'd0);

        // negative shift in RUN: sticky error, no pop
        drive(1'b1, 8'h77, 1'b0, 4'd0); tick();
        drive(1'b0, 8'h00, 1'b1, 4'hF);
        chk("neg_rb_valid", 32'(bus.byte_valid), 32'd0);
        chk("neg_rb_shifted", 32'(bus.byte_shifted), 32'd0);
        tick();
        chk("neg_rb_err", 32'(proto_err), 32'd1);
        chk("neg_rb_count", 32'(fifo_count), 32'd1);
        drive(1'b1, 8'h88, 1'b0, 4'd0); tick();
        drive(1'b0, 8'h00, 1'b0, 4'd0);
        chk("err_sticky", 32'(proto_err), 32'd1);
        chk("two_buffered", 32'(fifo_count), 32'd2);

        // async reset mid-RUN
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_err", 32'(proto_err), 32'd0);
        chk("arst_init_value", 32'(init_value), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b1, 8'h66, 1'b0, 4'd0);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("idle_count", 32'(fifo_count), 32'd0);

        // request during INIT
        start = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 4'd0);
        tick();
        start = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 4'd0);
        chk("init_req_valid", 32'(bus.byte_valid), 32'd0);
        tick();
        chk("init_req_err", 32'(proto_err), 32'd1);
        drive(1'b1, 8'hAB, 1'b0, 4'd0); tick();
        drive(1'b1, 8'hCD, 1'b0, 4'd0); tick();
        drive(1'b1, 8'hEF, 1'b0, 4'd0); tick();
        drive(1'b0, 8'h00, 1'b0, 4'd0);
        chk("init2_value", 32'(init_value), 32'hABCDEF);

        // start mid-RUN flushes the FIFO, init_value held
        drive(1'b1, 8'h01, 1'b0, 4'd0); tick();
        drive(1'b1, 8'h02, 1'b0, 4'd0); tick();
        chk("prestart_count", 32'(fifo_count), 32'd2);
        start = 1'b1;
        drive(1'b1, 8'h03, 1'b0, 4'd0);
        chk("restart_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        start = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 4'd0);
        chk("flush_count", 32'(fifo_count), 32'd0);
        chk("reinit_in_ready", 32'(bus.in_ready), 32'd1);
        chk("held_init_value", 32'(init_value), 32'hABCDEF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
